// File: rtl/apb_arch_pkg.sv
// apb_arch_pkg
// Shared definitions for the APB wait-state responder:
//   - apb_state_t   : responder FSM states
//   - CTRL_IDX      : word index of the CTRL register (wait count in [3:0])
//   - ID_IDX        : word index of the read-only ID register
//   - WAIT_W        : width of the wait counter / CTRL wait field
//   - decode_error  : address/access legality check for one transfer
//   - merge_bytes   : byte-strobe merge of write data into a register value
package apb_arch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        WAIT   = 2'd2,
        ACCESS = 2'd3
    } apb_state_t;

    localparam logic [5:0] CTRL_IDX = 6'd0;
    localparam logic [5:0] ID_IDX   = 6'd1;
    localparam int         WAIT_W   = 4;

    // Misaligned, beyond the register file, or a write to the ID register.
    function automatic logic decode_error(input logic [7:0] addr,
                                          input logic       write,
                                          input logic [6:0] nregs);
        logic err;
        err = 1'b0;
        if (addr[1:0] != 2'b00)
            err = 1'b1;
        if ({1'b0, addr[7:2]} >= nregs)
            err = 1'b1;
        if (write && (addr[7:2] == ID_IDX))
            err = 1'b1;
        return err;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_value;
        for (int k = 0; k < 4; k++) begin
            if (strb[k])
                result[8*k +: 8] = new_value[8*k +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter
// Down-counter that paces the wait states of one APB transfer.
//   clk, rst_n  : clock, asynchronous active-low reset (count cleared)
//   load        : load load_value (has priority over dec)
//   load_value  : wait count taken from CTRL
//   dec         : decrement by one, saturating at zero
//   count       : current count
//   zero        : count == 0
module apb_wait_counter
    import apb_arch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              dec,
    output logic [WAIT_W-1:0] count,
    output logic              zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apb_wait_responder.sv
// apb_wait_responder
// APB completer with a small register file and programmable wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   psel, penable, pwrite, paddr[7:0], pwdata[31:0], pstrb[3:0] : APB request
//   prdata[31:0], pready, pslverr : registered APB response
// Register 0 is CTRL (only [3:0] stored: wait count for later transfers),
// register 1 is a read-only ID, registers 2..NREGS-1 are plain storage.
module apb_wait_responder
    import apb_arch_pkg::*;
#(
    parameter int          NREGS    = 16,
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam logic [6:0] NREGS_L = 7'(NREGS);

    apb_state_t state_q;
    apb_state_t cur_state;
    apb_state_t next_state;

    logic [7:0]  addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;

    logic [31:0] regs [NREGS];

    logic              cnt_load;
    logic              cnt_dec;
    logic [WAIT_W-1:0] cnt_value;
    logic              cnt_zero;

    logic [7:0]  txn_addr;
    logic        txn_write;
    logic [31:0] txn_wdata;
    logic [3:0]  txn_strb;
    logic [5:0]  txn_idx;
    logic        txn_err;
    logic [31:0] rd_value;
    logic [31:0] merged;
    logic        commit;

    apb_wait_counter u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (regs[0][WAIT_W-1:0]),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    // SETUP is the APB setup phase itself: it is recognised from the live bus
    // while the register is IDLE, so a zero-wait transfer can raise the
    // registered pready in the very first access cycle. Leaving ACCESS
    // through IDLE costs nothing, since the next setup phase is picked up here
    // in the same cycle. penable=1 while idle is ignored.
    always_comb begin
        cur_state = state_q;
        if ((state_q == IDLE) && psel && !penable)
            cur_state = SETUP;
    end

    always_comb begin
        next_state = IDLE;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (cur_state)
            IDLE: begin
                next_state = IDLE;
            end
            SETUP: begin
                cnt_load   = 1'b1;
                next_state = (regs[0][WAIT_W-1:0] == '0) ? ACCESS : WAIT;
            end
            WAIT: begin
                if (!psel) begin
                    next_state = IDLE;
                end else begin
                    cnt_dec    = 1'b1;
                    next_state = (cnt_zero || (cnt_value == {{(WAIT_W-1){1'b0}}, 1'b1}))
                                 ? ACCESS : WAIT;
                end
            end
            ACCESS: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // During the setup phase the request fields are not latched yet, so the
    // live bus is used; afterwards the latched copy is authoritative.
    always_comb begin
        if (cur_state == SETUP) begin
            txn_addr  = paddr;
            txn_write = pwrite;
            txn_wdata = pwdata;
            txn_strb  = pstrb;
        end else begin
            txn_addr  = addr_q;
            txn_write = write_q;
            txn_wdata = wdata_q;
            txn_strb  = strb_q;
        end
    end

    assign txn_idx = txn_addr[7:2];
    assign txn_err = decode_error(txn_addr, txn_write, NREGS_L);
    assign commit  = (next_state == ACCESS);
    assign merged  = merge_bytes(rd_value, txn_wdata, txn_strb);

    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (txn_idx == 6'(i))
                rd_value = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            state_q <= next_state;
            if (cur_state == SETUP) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
            pready  <= commit;
            pslverr <= commit && txn_err;
            prdata  <= (commit && !txn_write && !txn_err) ? rd_value : '0;
        end
    end

    // The write lands on the edge that enters ACCESS, so the new value is in
    // place during the pready cycle. CTRL keeps only its wait field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == 1)
                    regs[i] <= ID_VALUE;
                else
                    regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (commit && txn_write && !txn_err && (txn_idx == 6'(i))) begin
                    if (i == 0)
                        regs[i] <= {{(32-WAIT_W){1'b0}}, merged[WAIT_W-1:0]};
                    else
                        regs[i] <= merged;
                end
            end
        end
    end

endmodule
